alarm_unit: RTL and testbench
=============================

Name: alarm_unit

Overview:
- Alarm register and ring controller, downstream of `counter` and in parallel with `Bigger_BCD`.
- Holds the settable alarm time (hr/min), compares it against the running time of day, and drives a ringing/buzzer output with snooze and auto-timeout.
- `alarm_hr_out`/`alarm_min_out` feed the BCD/display path when the FSM selects `mux` = 10 (regalarm).

Parameters:
- CLK_HZ, 10000: frequency of `clk` in Hz; sets all internal time bases.
- RING_SEC, 60: ringing auto-stop timeout in seconds.
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.
- RST_HR, 7: alarm hour after reset.
- RST_MIN, 0: alarm minute after reset.

Ports:
- clk  in  1  counter clock (clk_10000Hz domain)
- rst_n  in  1  asynchronous reset, active low
- setting_enable  in  1  regalarm_setting_enable from FSM
- set_hr_or_min  in  1  0 = edit hours, 1 = edit minutes
- inc_short  in  1  debounced increment level
- alarm_on  in  1  debounced arm switch level
- stop  in  1  debounced dismiss level
- snooze  in  1  debounced snooze level
- hours_in  in  14  running hours, 0..23
- minutes_in  in  14  running minutes, 0..59
- seconds_in  in  14  running seconds, 0..59
- alarm_hr_out  out  14  stored alarm hour
- alarm_min_out  out  14  stored alarm minute
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- buzzer  out  1  2 Hz square wave while ringing, else 0

Behaviour:
- Reset (async, rst_n=0):
  - alarm_hr_out=RST_HR, alarm_min_out=RST_MIN.
  - State IDLE; ringing=snoozing=buzzer=0.
  - All counters and edge registers cleared.
- Edge detection:
  - inc_short, stop and snooze are rising-edge detected (1-cycle pulse, registered).
  - A held level acts once only.
- Setting (setting_enable=1):
  - inc edge with set_hr_or_min=0: hr = (hr==23) ? 0 : hr+1.
  - inc edge with set_hr_or_min=1: min = (min==59) ? 0 : min+1.
  - Exactly one field changes per edge. The other field never carries.
  - Outputs update the cycle after the edge pulse.
  - setting_enable=1 forces IDLE and suppresses match detection.
- Match signal:
  - `match` = hours_in==alarm_hr && minutes_in==alarm_min && seconds_in==0.
  - A trigger is the rising edge of `match` (registered compare), so a whole-second match triggers once.
- States:
  - IDLE → RINGING: on trigger when alarm_on=1 and setting_enable=0.
  - RINGING → IDLE: on stop edge, or when the ring timer reaches CLK_HZ*RING_SEC-1.
  - RINGING → SNOOZE: on snooze edge.
    - Capture the target as (current hr:min + SNOOZE_MIN), minutes mod 60 with carry into hours mod 24.
    - Example: 23:58 + 5 → 00:03.
  - SNOOZE → RINGING: on rising edge of snooze-target match (hours_in/minutes_in equal target, seconds_in==0).
    - The ring timer restarts from 0.
  - SNOOZE → IDLE: on stop edge.
- Entering RINGING clears the ring timer and the buzzer divider.
- Priority, highest first:
  1. rst_n
  2. alarm_on=0 (→ IDLE)
  3. setting_enable=1 (→ IDLE)
  4. stop
  5. snooze
  6. timeout
  7. trigger
- Simultaneous cases:
  - stop+snooze in the same cycle → IDLE.
  - timeout and snooze in the same cycle → SNOOZE.
- Buzzer:
  - buzzer=1 on the first RINGING cycle.
  - Toggles every CLK_HZ/4 cycles (2 Hz).
  - Forced 0 outside RINGING, registered.
- Outputs ringing and snoozing are registered state decodes.
- Width rules:
  - All time fields are 14-bit unsigned; only values 0..59 / 0..23 are legal.
  - The ring timer is sized $clog2(CLK_HZ*RING_SEC).

Decomposition:
- Shared package time_pkg:
  - HR_MAX=23, MIN_MAX=59, TIME_W=14.
  - alarm_state_t enum {IDLE, RINGING, SNOOZE}.
  - Function add_minutes(hr, min, n) returning the wrapped hr/min.
- One sub-module: rise_edge (registered rising-edge pulse), instantiated three times.

Test Plan:
All tests use CLK_HZ=8, RING_SEC=2 unless stated.
- Reset: rst_n low mid-RINGING → ringing=buzzer=0 immediately; alarm_hr_out=7, alarm_min_out=0.
- Setting: setting_enable=1, set_hr_or_min=0, 18 inc edges from 07 → alarm_hr_out=1 (wrap via 23→0); set_hr_or_min=1, 60 edges → min returns to 0, hr unchanged at 1; a held inc counts once.
- Trigger and timeout: alarm 07:00, alarm_on=1, time 06:59:59 → 07:00:00 → ringing=1 one cycle after the match; buzzer high 2 cycles, low 2; ringing=0 after 16 cycles; no retrigger while seconds_in stays 0.
- Snooze wrap: alarm 23:58 ringing; snooze edge → snoozing=1; time 00:03:00 → ringing=1; stop edge → IDLE, all outputs 0.
- Priority: stop and snooze edges in the same cycle while RINGING → IDLE; alarm_on=0 during SNOOZE → IDLE; setting_enable=1 at the match instant → no ring.
- Disarmed: alarm_on=0, time passes 07:00:00 → ringing stays 0.

Source files
------------

// File: rtl/time_pkg.sv
// Shared time-of-day types and helpers for the alarm path.
package time_pkg;

    localparam int TIME_W  = 14;
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hr;
        logic [TIME_W-1:0] mn;
    } hm_t;

    // Adds n minutes (n <= 59) to hr:mn, wrapping minutes mod 60 with a
    // single carry into hours mod 24.
    function automatic hm_t add_minutes(input logic [TIME_W-1:0] hr,
                                        input logic [TIME_W-1:0] mn,
                                        input logic [TIME_W-1:0] n);
        hm_t             r;
        logic [TIME_W:0] sum;
        sum = {1'b0, mn} + {1'b0, n};
        if (sum > (TIME_W+1)'(MIN_MAX)) begin
            r.mn = TIME_W'(sum - (TIME_W+1)'(MIN_MAX + 1));
            r.hr = (hr >= TIME_W'(HR_MAX)) ? '0 : hr + TIME_W'(1);
        end else begin
            r.mn = sum[TIME_W-1:0];
            r.hr = hr;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember the previous level and register the edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm time register plus ring / snooze controller with buzzer output.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for alarm time match (or disarmed / being set)
//   RINGING | buzzer active, ring timer running toward auto-stop
//   SNOOZE  | silent, waiting for the captured snooze target time
module alarm_unit
    import time_pkg::*;
#(
    parameter int CLK_HZ     = 10000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int RST_HR     = 7,
    parameter int RST_MIN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setting_enable,
    input  logic              set_hr_or_min,
    input  logic              inc_short,
    input  logic              alarm_on,
    input  logic              stop,
    input  logic              snooze,
    input  logic [TIME_W-1:0] hours_in,
    input  logic [TIME_W-1:0] minutes_in,
    input  logic [TIME_W-1:0] seconds_in,
    output logic [TIME_W-1:0] alarm_hr_out,
    output logic [TIME_W-1:0] alarm_min_out,
    output logic              ringing,
    output logic              snoozing,
    output logic              buzzer
);

    localparam int RING_CYC = CLK_HZ * RING_SEC;
    localparam int RT_W     = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RING_CYC - 1);

    // Buzzer half period: CLK_HZ/4 cycles gives a 2 Hz square wave.
    localparam int BZ_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BZ_W    = (BZ_HALF > 1) ? $clog2(BZ_HALF) : 1;
    localparam logic [BZ_W-1:0] BZ_LAST = BZ_W'(BZ_HALF - 1);

    localparam logic [TIME_W-1:0] SNZ_N = TIME_W'(SNOOZE_MIN);

    logic              inc_p;
    logic              stop_p;
    logic              snooze_p;

    logic [TIME_W-1:0] alarm_hr;
    logic [TIME_W-1:0] alarm_min;

    logic              match_now;
    logic              match_q;
    logic              trigger;

    logic [TIME_W-1:0] snz_hr;
    logic [TIME_W-1:0] snz_min;
    logic              snz_match_now;
    logic              snz_match_q;
    logic              snz_trigger;

    hm_t               snz_target;

    alarm_state_t      state;
    logic [RT_W-1:0]   ring_cnt;
    logic [BZ_W-1:0]   bz_cnt;
    logic              timeout;

    rise_edge u_inc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (inc_short),
        .pulse (inc_p)
    );

    rise_edge u_stop_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (stop),
        .pulse (stop_p)
    );

    rise_edge u_snooze_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (snooze),
        .pulse (snooze_p)
    );

    assign alarm_hr_out  = alarm_hr;
    assign alarm_min_out = alarm_min;

    // Alarm register: each increment edge bumps exactly one field, no carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hr  <= TIME_W'(RST_HR);
            alarm_min <= TIME_W'(RST_MIN);
        end else if (setting_enable && inc_p) begin
            if (!set_hr_or_min) begin
                alarm_hr <= (alarm_hr == TIME_W'(HR_MAX)) ? '0 : alarm_hr + TIME_W'(1);
            end else begin
                alarm_min <= (alarm_min == TIME_W'(MIN_MAX)) ? '0 : alarm_min + TIME_W'(1);
            end
        end
    end

    assign match_now = (hours_in == alarm_hr) && (minutes_in == alarm_min) &&
                       (seconds_in == '0);
    assign snz_match_now = (hours_in == snz_hr) && (minutes_in == snz_min) &&
                           (seconds_in == '0);

    // Only the first cycle of a whole matching second counts as a trigger.
    assign trigger     = match_now & ~match_q;
    assign snz_trigger = snz_match_now & ~snz_match_q;

    assign timeout    = (ring_cnt == RT_LAST);
    assign snz_target = add_minutes(hours_in, minutes_in, SNZ_N);

    // Previous-cycle compare results for the trigger edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q     <= 1'b0;
            snz_match_q <= 1'b0;
        end else begin
            match_q     <= match_now;
            snz_match_q <= snz_match_now;
        end
    end

    // Ring controller with registered state decodes and buzzer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
            buzzer   <= 1'b0;
            ring_cnt <= '0;
            bz_cnt   <= '0;
            snz_hr   <= '0;
            snz_min  <= '0;
        end else if (!alarm_on || setting_enable) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
            buzzer   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                        buzzer   <= 1'b1;
                        ring_cnt <= '0;
                        bz_cnt   <= '0;
                    end
                end
                RINGING: begin
                    if (stop_p) begin
                        state    <= IDLE;
                        ringing  <= 1'b0;
                        snoozing <= 1'b0;
                        buzzer   <= 1'b0;
                    end else if (snooze_p) begin
                        state    <= SNOOZE;
                        ringing  <= 1'b0;
                        snoozing <= 1'b1;
                        buzzer   <= 1'b0;
                        snz_hr   <= snz_target.hr;
                        snz_min  <= snz_target.mn;
                    end else if (timeout) begin
                        state    <= IDLE;
                        ringing  <= 1'b0;
                        snoozing <= 1'b0;
                        buzzer   <= 1'b0;
                    end else begin
                        ring_cnt <= ring_cnt + RT_W'(1);
                        if (bz_cnt == BZ_LAST) begin
                            bz_cnt <= '0;
                            buzzer <= ~buzzer;
                        end else begin
                            bz_cnt <= bz_cnt + BZ_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_p) begin
                        state    <= IDLE;
                        ringing  <= 1'b0;
                        snoozing <= 1'b0;
                        buzzer   <= 1'b0;
                    end else if (snz_trigger) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                        buzzer   <= 1'b1;
                        ring_cnt <= '0;
                        bz_cnt   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                    buzzer   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit with a fast clock (CLK_HZ=8, RING_SEC=2).
module tb_alarm_unit;

    localparam int SEL_HR   = 0;
    localparam int SEL_MIN  = 1;
    localparam int SEL_RING = 2;
    localparam int SEL_SNZ  = 3;
    localparam int SEL_BUZ  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        setting_enable;
    logic        set_hr_or_min;
    logic        inc_short;
    logic        alarm_on;
    logic        stop;
    logic        snooze;
    logic [13:0] hours_in;
    logic [13:0] minutes_in;
    logic [13:0] seconds_in;
    logic [13:0] alarm_hr_out;
    logic [13:0] alarm_min_out;
    logic        ringing;
    logic        snoozing;
    logic        buzzer;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    alarm_unit #(
        .CLK_HZ     (8),
        .RING_SEC   (2),
        .SNOOZE_MIN (5),
        .RST_HR     (7),
        .RST_MIN    (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .setting_enable (setting_enable),
        .set_hr_or_min  (set_hr_or_min),
        .inc_short      (inc_short),
        .alarm_on       (alarm_on),
        .stop           (stop),
        .snooze         (snooze),
        .hours_in       (hours_in),
        .minutes_in     (minutes_in),
        .seconds_in     (seconds_in),
        .alarm_hr_out   (alarm_hr_out),
        .alarm_min_out  (alarm_min_out),
        .ringing        (ringing),
        .snoozing       (snoozing),
        .buzzer         (buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            SEL_HR:   return int'(alarm_hr_out);
            SEL_MIN:  return int'(alarm_min_out);
            SEL_RING: return int'(ringing);
            SEL_SNZ:  return int'(snoozing);
            default:  return int'(buzzer);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours_in   = 14'(h);
        minutes_in = 14'(m);
        seconds_in = 14'(s);
    endtask

    task automatic press_inc();
        inc_short = 1'b1;
        tick(1);
        inc_short = 1'b0;
        tick(1);
    endtask

    task automatic press_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        tick(1);
        snooze = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        push("rst_hr", SEL_HR, 7);
        push("rst_min", SEL_MIN, 0);
        push("rst_ring", SEL_RING, 0);
        push("rst_snz", SEL_SNZ, 0);
        push("rst_buz", SEL_BUZ, 0);
        check_all();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Bring the clock to a non-matching time, then step onto h:m:00.
    task automatic ring_at(input int h, input int m);
        set_time(h, m, 30);
        tick(2);
        set_time(h, m, 0);
        tick(1);
    endtask

    initial begin
        rst_n          = 1'b0;
        setting_enable = 1'b0;
        set_hr_or_min  = 1'b0;
        inc_short      = 1'b0;
        alarm_on       = 1'b0;
        stop           = 1'b0;
        snooze         = 1'b0;
        set_time(12, 30, 30);
        tick(1);
        do_reset();

        // Alarm setting: hour wrap, minute wrap, held increment
        setting_enable = 1'b1;
        set_hr_or_min  = 1'b0;
        for (int i = 0; i < 18; i++) press_inc();
        push("set_hr_wrap", SEL_HR, 1);
        push("set_hr_min_untouched", SEL_MIN, 0);
        check_all();
        set_hr_or_min = 1'b1;
        for (int i = 0; i < 59; i++) press_inc();
        push("set_min_59", SEL_MIN, 59);
        check_all();
        press_inc();
        push("set_min_wrap", SEL_MIN, 0);
        push("set_min_no_carry", SEL_HR, 1);
        check_all();
        inc_short = 1'b1;
        tick(6);
        inc_short = 1'b0;
        tick(1);
        push("held_inc_once", SEL_MIN, 1);
        check_all();
        setting_enable = 1'b0;
        do_reset();

        // Trigger, buzzer pattern, timeout, no retrigger
        alarm_on = 1'b1;
        set_time(6, 59, 59);
        tick(2);
        push("pre_match_ring", SEL_RING, 0);
        check_all();
        set_time(7, 0, 0);
        for (int j = 0; j < 16; j++) begin
            tick(1);
            push($sformatf("ring_c%0d", j), SEL_RING, 1);
            push($sformatf("buz_c%0d", j), SEL_BUZ, (((j >> 1) % 2) == 0) ? 1 : 0);
            check_all();
        end
        tick(1);
        push("timeout_ring", SEL_RING, 0);
        push("timeout_buz", SEL_BUZ, 0);
        check_all();
        tick(10);
        push("no_retrigger", SEL_RING, 0);
        check_all();

        // Snooze across midnight: 23:58 + 5 -> 00:03
        setting_enable = 1'b1;
        set_hr_or_min  = 1'b0;
        for (int i = 0; i < 16; i++) press_inc();
        set_hr_or_min = 1'b1;
        for (int i = 0; i < 58; i++) press_inc();
        setting_enable = 1'b0;
        push("alarm_hr_2358", SEL_HR, 23);
        push("alarm_min_2358", SEL_MIN, 58);
        check_all();
        ring_at(23, 58);
        push("wrap_ring", SEL_RING, 1);
        check_all();
        press_snooze();
        push("snz_state", SEL_SNZ, 1);
        push("snz_ring_off", SEL_RING, 0);
        push("snz_buz_off", SEL_BUZ, 0);
        check_all();
        set_time(0, 2, 59);
        tick(3);
        push("snz_wait", SEL_SNZ, 1);
        push("snz_wait_ring", SEL_RING, 0);
        check_all();
        set_time(0, 3, 0);
        tick(1);
        push("snz_rering", SEL_RING, 1);
        push("snz_rering_snz", SEL_SNZ, 0);
        push("snz_rering_buz", SEL_BUZ, 1);
        check_all();
        press_stop();
        push("stop_ring", SEL_RING, 0);
        push("stop_snz", SEL_SNZ, 0);
        push("stop_buz", SEL_BUZ, 0);
        check_all();

        // Priority cases, alarm back at 07:00
        do_reset();
        alarm_on = 1'b1;
        ring_at(7, 0);
        push("prio_ring", SEL_RING, 1);
        check_all();
        stop   = 1'b1;
        snooze = 1'b1;
        tick(1);
        stop   = 1'b0;
        snooze = 1'b0;
        tick(1);
        push("stop_snz_ring", SEL_RING, 0);
        push("stop_snz_snz", SEL_SNZ, 0);
        check_all();
        ring_at(7, 0);
        press_snooze();
        push("prio_in_snz", SEL_SNZ, 1);
        check_all();
        alarm_on = 1'b0;
        tick(1);
        push("disarm_snz", SEL_SNZ, 0);
        push("disarm_ring", SEL_RING, 0);
        check_all();
        alarm_on = 1'b1;
        set_time(6, 59, 59);
        tick(2);
        setting_enable = 1'b1;
        set_time(7, 0, 0);
        tick(3);
        push("setting_blocks", SEL_RING, 0);
        check_all();
        setting_enable = 1'b0;
        tick(3);
        push("setting_no_late", SEL_RING, 0);
        check_all();

        // Disarmed alarm never rings
        alarm_on = 1'b0;
        ring_at(7, 0);
        tick(20);
        push("disarmed_ring", SEL_RING, 0);
        push("disarmed_buz", SEL_BUZ, 0);
        check_all();

        // Async reset while ringing restores the reset alarm time
        alarm_on       = 1'b1;
        setting_enable = 1'b1;
        set_hr_or_min  = 1'b0;
        press_inc();
        setting_enable = 1'b0;
        push("alarm_hr_8", SEL_HR, 8);
        check_all();
        ring_at(8, 0);
        tick(2);
        push("pre_rst_ring", SEL_RING, 1);
        check_all();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
